// File: rtl/mul_issue_ctrl_if.sv
// Handshake bundle between the multiply reservation stations,
// the multiplier issue controller and the CDB arbiter.
interface mul_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             rs0_valid;
  logic             rs0_ready;
  logic [TAG_W-1:0] rs0_tag;
  logic [63:0]      rs0_a;
  logic [63:0]      rs0_b;
  logic             rs1_valid;
  logic             rs1_ready;
  logic [TAG_W-1:0] rs1_tag;
  logic [63:0]      rs1_a;
  logic [63:0]      rs1_b;
  logic             flush;
  logic             cdb_valid;
  logic             cdb_ready;
  logic [TAG_W-1:0] cdb_tag;
  logic [127:0]     cdb_res;
  logic             busy;

  modport slave (
    input  rs0_valid, rs0_tag, rs0_a, rs0_b,
    input  rs1_valid, rs1_tag, rs1_a, rs1_b,
    input  flush, cdb_ready,
    output rs0_ready, rs1_ready,
    output cdb_valid, cdb_tag, cdb_res, busy
  );

  modport master (
    output rs0_valid, rs0_tag, rs0_a, rs0_b,
    output rs1_valid, rs1_tag, rs1_a, rs1_b,
    output flush, cdb_ready,
    input  rs0_ready, rs1_ready,
    input  cdb_valid, cdb_tag, cdb_res, busy
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Round-robin issue and CDB writeback around a 64x64 multiplier.
// Define MUL_SIGNED_EN for two's-complement operands.
module wallace64 (
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [127:0] p
);
  assign p = {64'd0, a} * {64'd0, b};
endmodule

module mul_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int PIPE  = 2
) (
  input logic            clk,
  input logic            rst_n,
  mul_issue_ctrl_if.slave bus
);
  logic             last;
  logic             adv;
  logic             g0;
  logic             g1;
  logic             ok;
  logic             take;
  logic             s1_v;
  logic [TAG_W-1:0] s1_tag;
  logic [63:0]      s1_a;
  logic [63:0]      s1_b;
  logic [63:0]      op_a;
  logic [63:0]      op_b;
  logic [127:0]     mul_p;
  logic [127:0]     prod;
  logic [PIPE:2]    v_q;
  logic [TAG_W-1:0] tag_q [2:PIPE];
  logic [127:0]     res_q [2:PIPE];

  assign adv  = !v_q[PIPE] | bus.cdb_ready;
  assign g0   = bus.rs0_valid & (!bus.rs1_valid | last);
  assign g1   = bus.rs1_valid & (!bus.rs0_valid | !last);
  // rst_n gate keeps ready low while the pipe is held in reset
  assign ok   = adv & !bus.flush & rst_n;
  assign take = bus.rs0_ready | bus.rs1_ready;

  assign bus.rs0_ready = g0 & ok;
  assign bus.rs1_ready = g1 & ok;
  assign bus.cdb_valid = v_q[PIPE];
  assign bus.cdb_tag   = tag_q[PIPE];
  assign bus.cdb_res   = res_q[PIPE];
  assign bus.busy      = s1_v | (|v_q);

`ifdef MUL_SIGNED_EN
  logic neg;
  // -2^63 negates to itself, which reads as 2^63 unsigned
  assign op_a = s1_a[63] ? -s1_a : s1_a;
  assign op_b = s1_b[63] ? -s1_b : s1_b;
  assign neg  = s1_a[63] ^ s1_b[63];
  assign prod = neg ? -mul_p : mul_p;
`else
  assign op_a = s1_a;
  assign op_b = s1_b;
  assign prod = mul_p;
`endif

  wallace64 u_mul (
    .a (op_a),
    .b (op_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_tag <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      last   <= 1'b1;
    end else begin
      if (adv) begin
        s1_v <= take;
        unique case (1'b1)
          bus.rs0_ready: begin
            s1_tag <= bus.rs0_tag;
            s1_a   <= bus.rs0_a;
            s1_b   <= bus.rs0_b;
          end
          bus.rs1_ready: begin
            s1_tag <= bus.rs1_tag;
            s1_a   <= bus.rs1_a;
            s1_b   <= bus.rs1_b;
          end
          default: ;
        endcase
      end
      if (bus.flush) s1_v <= 1'b0;
      if (take) last <= bus.rs1_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 2; k <= PIPE; k++) begin
        tag_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      if (adv) begin
        v_q[2]   <= s1_v;
        tag_q[2] <= s1_tag;
        res_q[2] <= prod;
        for (int k = 3; k <= PIPE; k++) begin
          v_q[k]   <= v_q[k-1];
          tag_q[k] <= tag_q[k-1];
          res_q[k] <= res_q[k-1];
        end
      end
      if (bus.flush) v_q <= '0;
    end
  end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomized bench for mul_issue_ctrl against a slot-level model.
// Honours MUL_SIGNED_EN for the expected products.
module tb_mul_issue_ctrl;
  localparam int TAG_W = 4;
  localparam int P     = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  mul_issue_ctrl #(
    .TAG_W (TAG_W),
    .PIPE  (P)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit              m_v   [P];
  logic [TAG_W-1:0] m_tag [P];
  logic [127:0]    m_res [P];
  bit              m_last;
  logic [15:0]     got_tags;

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(logic [63:0] a,
                                           logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
`ifdef MUL_SIGNED_EN
    sa = $signed({{64{a[63]}}, a});
    sb = $signed({{64{b[63]}}, b});
`else
    sa = $signed({64'd0, a});
    sb = $signed({64'd0, b});
`endif
    return 128'(sa * sb);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < P; i++) m_v[i] = 0;
    m_last = 1;
  endtask

  task automatic drive(bit v0, int t0, logic [63:0] a0,
                       logic [63:0] b0, bit v1, int t1,
                       logic [63:0] a1, logic [63:0] b1,
                       bit fl, bit rdy);
    bus.rs0_valid = v0;
    bus.rs0_tag   = TAG_W'(t0);
    bus.rs0_a     = a0;
    bus.rs0_b     = b0;
    bus.rs1_valid = v1;
    bus.rs1_tag   = TAG_W'(t1);
    bus.rs1_a     = a1;
    bus.rs1_b     = b1;
    bus.flush     = fl;
    bus.cdb_ready = rdy;
  endtask

  task automatic idle(bit rdy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic step();
    bit adv;
    bit e0;
    bit e1;
    bit any;
    #1;
    adv = !m_v[P-1] || bus.cdb_ready;
    e0 = bus.rs0_valid && (!bus.rs1_valid || m_last)
         && adv && !bus.flush;
    e1 = bus.rs1_valid && (!bus.rs0_valid || !m_last)
         && adv && !bus.flush;
    any = 0;
    for (int i = 0; i < P; i++) any |= m_v[i];
    check("rs0_ready", 128'(bus.rs0_ready), 128'(e0));
    check("rs1_ready", 128'(bus.rs1_ready), 128'(e1));
    check("cdb_valid", 128'(bus.cdb_valid), 128'(m_v[P-1]));
    check("busy", 128'(bus.busy), 128'(any));
    if (m_v[P-1]) begin
      check("cdb_tag", 128'(bus.cdb_tag), 128'(m_tag[P-1]));
      check("cdb_res", bus.cdb_res, m_res[P-1]);
    end
    if (bus.cdb_valid && bus.cdb_ready)
      got_tags = {got_tags[11:0], bus.cdb_tag};
    @(posedge clk);
    if (bus.flush) begin
      for (int i = 0; i < P; i++) m_v[i] = 0;
    end else if (adv) begin
      for (int i = P - 1; i > 0; i--) begin
        m_v[i]   = m_v[i-1];
        m_tag[i] = m_tag[i-1];
        m_res[i] = m_res[i-1];
      end
      m_v[0] = e0 || e1;
      m_tag[0] = e0 ? bus.rs0_tag : bus.rs1_tag;
      m_res[0] = e0 ? ref_mul(bus.rs0_a, bus.rs0_b)
                    : ref_mul(bus.rs1_a, bus.rs1_b);
    end
    if (e0 || e1) m_last = e1;
    @(negedge clk);
  endtask

  task automatic run_one(int tag, logic [63:0] a,
                         logic [63:0] b, logic [127:0] exp,
                         string name);
    drive(1, tag, a, b, 0, 0, 0, 0, 0, 1);
    step();
    idle(1);
    for (int i = 0; i < P - 1; i++) step();
    #1;
    check(name, bus.cdb_res, exp);
    step();
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] c [5];
    c[0] = 64'd0;
    c[1] = 64'd1;
    c[2] = '1;
    c[3] = 64'h8000_0000_0000_0000;
    c[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    if ($urandom_range(3) == 0) return c[$urandom_range(4)];
    return {$urandom, $urandom};
  endfunction

  logic [127:0] exp_neg8;
  logic [127:0] exp_min;
  logic [127:0] exp_ones;
  logic [3:0]   grants;
  logic [63:0]  ones;

  initial begin
    checks   = 0;
    failures = 0;
    got_tags = '0;
    ones     = '1;
`ifdef MUL_SIGNED_EN
    exp_neg8 = 128'd0 - 128'd80;
    exp_min  = 128'h0000_0000_0000_0000_8000_0000_0000_0000;
    exp_ones = 128'd1;
`else
    exp_neg8 = 128'h0000_0000_0000_0009_FFFF_FFFF_FFFF_FFB0;
    exp_min  = 128'h7FFF_FFFF_FFFF_FFFF_8000_0000_0000_0000;
    exp_ones = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
`endif
    model_reset();
    rst_n = 1'b0;
    drive(1, 1, 3, 3, 1, 2, 4, 4, 0, 1);
    #2;
    check("rst_cdb_valid", 128'(bus.cdb_valid), 0);
    check("rst_cdb_tag", 128'(bus.cdb_tag), 0);
    check("rst_cdb_res", bus.cdb_res, 0);
    check("rst_busy", 128'(bus.busy), 0);
    check("rst_rs0_ready", 128'(bus.rs0_ready), 0);
    check("rst_rs1_ready", 128'(bus.rs1_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    grants   = '0;
    got_tags = '0;
    for (int i = 0; i < 4; i++) begin
      drive(1, (i < 2) ? 1 : 2, 64'(i + 3), 7,
            1, (i < 3) ? 5 : 6, 64'(i + 9), 11, 0, 1);
      if (i == 1) bus.rs0_tag = (grants[0]) ? 4'd1 : 4'd2;
      if (i == 2) bus.rs1_tag = (grants[1:0] == 2'b10) ? 4'd6 : 4'd5;
      #1;
      grants = {grants[2:0], bus.rs1_ready};
      step();
    end
    idle(1);
    for (int i = 0; i < P + 1; i++) step();
    check("grant_order", 128'(grants), 128'(4'b0101));
    check("cdb_order", 128'(got_tags), 128'(16'h1526));

    run_one(3, 8, 10, 128'd80, "single_res");
    #1;
    check("single_busy", 128'(bus.busy), 0);
    step();

    drive(1, 7, ones, ones, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 8, 5, 5, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_res", bus.cdb_res, exp_ones);
      check("bp_rs0_ready", 128'(bus.rs0_ready), 0);
      step();
    end
    idle(1);
    for (int i = 0; i < P + 1; i++) step();

    drive(1, 11, 2, 3, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 12, 4, 5, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 13, 6, 7, 0, 0, 0, 0, 1, 0);
    #1;
    check("flush_rs0_ready", 128'(bus.rs0_ready), 0);
    step();
    idle(1);
    #1;
    check("flush_cdb_valid", 128'(bus.cdb_valid), 0);
    check("flush_busy", 128'(bus.busy), 0);
    for (int i = 0; i < P + 1; i++) step();

    run_one(4, 64'hFFFF_FFFF_FFFF_FFF8, 10, exp_neg8, "neg8_res");
    run_one(5, 64'h8000_0000_0000_0000, ones, exp_min, "min_res");

    drive(1, 1, 9, 9, 0, 2, 3, 3, 0, 1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cdb_valid", 128'(bus.cdb_valid), 0);
    check("arst_busy", 128'(bus.busy), 0);
    check("arst_rs0_ready", 128'(bus.rs0_ready), 0);
    check("arst_rs1_ready", 128'(bus.rs1_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 9, 1, 1, 1, 10, 2, 2, 0, 1);
    #1;
    check("arst_first_rs0", 128'(bus.rs0_ready), 1);
    check("arst_first_rs1", 128'(bus.rs1_ready), 0);
    step();

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(3) != 0, int'($urandom_range(15)),
            rand_op(), rand_op(),
            $urandom_range(3) != 0, int'($urandom_range(15)),
            rand_op(), rand_op(),
            $urandom_range(30) == 0, $urandom_range(9) < 7);
      step();
    end
    idle(1);
    for (int i = 0; i < P + 1; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Issue and writeback controller for the 64-bit Wallace-tree multiplier in the Tomasulo multiply functional unit. It arbitrates round-robin between two multiply reservation stations and feeds operands into a register-staged pipeline around a combinational `wallace64` instance. Results are returned as tagged 128-bit products on a valid/ready common-data-bus port. Throughput is one multiply per cycle, with full backpressure from the CDB arbiter.

## Interface
- `TAG_W`, 4: width of the reservation-station tag carried with each op.
- `PIPE`, 2: register stages from operand capture to CDB output; legal range 2..4.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs0_valid` in 1: RS0 has a ready multiply op.
- `rs0_ready` out 1: RS0 op accepted this cycle.
- `rs0_tag` in TAG_W: RS0 destination tag.
- `rs0_a`, `rs0_b` in 64: RS0 operands.
- `rs1_valid`, `rs1_ready`, `rs1_tag`, `rs1_a`, `rs1_b`: same meanings for RS1.
- `flush` in 1: synchronous kill of all in-flight ops (mispredict recovery).
- `cdb_valid` out 1: product available.
- `cdb_ready` in 1: CDB grant; the output transfers when `cdb_valid & cdb_ready`.
- `cdb_tag` out TAG_W: tag of the presented product.
- `cdb_res` out 128: product.
- `busy` out 1: any pipeline stage holds a valid op.

## Operation
- Stages S1..S_PIPE each hold a valid bit, tag, and data.
  - S1 holds the operands.
  - `wallace64` multiplies the S1 operands combinationally.
  - S2..S_PIPE hold the 128-bit product.
  - S_PIPE drives the `cdb_*` outputs.
- Advance condition: `adv = !S_PIPE.valid | cdb_ready`.
  - When `adv` is 1, all stages shift one place in the same edge.
  - When `adv` is 0, all stages hold (global stall); bubbles are not collapsed.
- Arbitration:
  - `last` pointer: 0 or 1.
  - If both requesters are valid, grant the one not equal to `last`; otherwise grant whichever is valid.
  - `rsX_ready = grant_X & adv & !flush`; the ready is combinational from valid.
  - On acceptance, `last` updates to the accepted index, and S1 loads that requester's tag and operands with valid=1.
  - If nothing is accepted on an advancing edge, S1 loads valid=0.
- Arithmetic: the 128-bit product is carried without truncation. Data in invalid stages is don't-care but must be deterministic (held or zero).
- Flush:
  - When `flush` is 1 at an edge, all valid bits clear, regardless of `adv` and `cdb_ready`.
  - No request is accepted in that cycle.
  - A CDB transfer in the flush cycle is still considered completed by the receiver if `cdb_valid & cdb_ready` were both high.
- Reset (async, `rst_n` = 0):
  - All valid bits are 0, so `cdb_valid`, `rs0_ready`, `rs1_ready`, and `busy` are 0.
  - `cdb_tag` and `cdb_res` are 0.
  - `last` is 1, so RS0 wins the first contention.
  - Reset mid-operation discards every op with no output.

## Timing
- Latency: an op accepted at edge n shows `cdb_valid` = 1 after edge n+PIPE−1, i.e. PIPE cycles from request to result when unstalled.
- Throughput: one accept per cycle while `cdb_ready` stays 1.
- The `cdb_*` outputs are held stable while `cdb_valid & !cdb_ready`.
- Accept and CDB transfer in the same cycle are legal; the pipeline shifts and the new op enters S1.
- `busy` is registered-derived: it is the OR of the stage valid bits.
- The critical path is S1 registers → `wallace64` → S2; PIPE ≥ 2 guarantees the multiplier output is always registered.

## Configuration
- `MUL_SIGNED_EN`
  - Defined:
    - Operands are two's complement.
    - Absolute values of S1 `a` and `b` feed `wallace64`.
    - The product is negated (two's complement, 128-bit) before entering S2 when the operand sign bits differ.
    - −2^63 is handled as magnitude 2^63; the result must be exact.
  - Undefined: operands are unsigned and the `wallace64` output passes straight to S2.

## Test plan
- Single op, PIPE=2, `cdb_ready` held 1:
  - Stimulus: RS0 a=8, b=10, tag=3.
  - Expected: `rs0_ready` = 1 for one cycle; `cdb_valid` high 2 cycles after the request with tag=3 and res=80; `busy` then falls.
- Contention:
  - Stimulus: both RS valid for 4 cycles (RS0 tags 1,2; RS1 tags 5,6).
  - Expected: grant order RS0, RS1, RS0, RS1; CDB tags in order 1, 5, 2, 6.
- Backpressure:
  - Stimulus: `cdb_ready` = 0 for 3 cycles with a result at the output, a=2^64−1, b=2^64−1.
  - Expected: `cdb_res` = 0xFFFFFFFFFFFFFFFE0000000000000001 held stable; `rs*_ready` = 0 while the pipe is full; the result transfers on `cdb_ready` = 1.
- Flush:
  - Stimulus: 2 ops in flight, assert `flush` with `rs0_valid` = 1.
  - Expected: `rs0_ready` = 0; next cycle `cdb_valid` = 0 and `busy` = 0; no stale tag ever appears.
- Async reset mid-stream:
  - Stimulus: drop `rst_n` between clock edges.
  - Expected: `cdb_valid`, `busy`, and `rs*_ready` go 0 immediately; after release, the first contention grants RS0.
- `MUL_SIGNED_EN` defined:
  - Stimulus: a=−8, b=10.
  - Expected: res=−80 (0xFFFF…FFB0).
  - Stimulus: a=−2^63, b=−1.
  - Expected: res=2^63.
  - With the macro undefined, a=−8, b=10 gives the unsigned product.
